// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  localparam int WIDTH_DEF = 32;

  // LO is filled with this bit on divide-by-zero, giving all ones.
  localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude on capture, sign restore in FIX.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
module hilo_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             Mul,
  input  logic             Div,
  input  logic             Unsigned,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     a_q, b_q, raw_a_q, rem_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 sq_q, sr_q, div_q, dz_q, busy_q, done_q;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [WIDTH-1:0]     rem_d, quo_d;

  assign a_neg = ~Unsigned & op_a[WIDTH-1];
  assign b_neg = ~Unsigned & op_b[WIDTH-1];

  muldiv_sign_fix #(.W(WIDTH)) u_fix_a (.val_i(op_a), .neg_i(a_neg), .res_o(a_mag));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_b (.val_i(op_b), .neg_i(b_neg), .res_o(b_mag));
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_p (.val_i(acc_q), .neg_i(sq_q), .res_o(prod_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_q (.val_i(acc_q[WIDTH-1:0]), .neg_i(sq_q), .res_o(quo_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_r (.val_i(rem_q), .neg_i(sr_q), .res_o(rem_fix));

  // Multiply: the multiplier sits in the low half and shifts out as the product shifts in.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: dividend bits leave the low half MSB-first while quotient bits enter at the LSB.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign rem_d     = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_d     = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      raw_a_q <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue && (Mul || Div)) begin
            state_q <= Mul ? MUL : DIV;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            a_q     <= a_mag;
            b_q     <= b_mag;
            raw_a_q <= op_a;
            dz_q    <= (op_b == '0);
            div_q   <= ~Mul;
            sq_q    <= a_neg ^ b_neg;
            sr_q    <= a_neg;
            rem_q   <= '0;
            acc_q   <= Mul ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
          end else begin
            if (MTHI) hi_q <= op_a;
            if (MTLO) lo_q <= op_a;
          end
        end
        MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        DIV: begin
          acc_q <= {acc_q[2*WIDTH-1:WIDTH], quo_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          if (!div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_q <= raw_a_q;
            lo_q <= {WIDTH{DIV0_LO_BIT}};
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expectations queued at issue, checked on done.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue, Mul, Div, Unsigned, MTHI, MTLO;
  logic [31:0] op_a, op_b;
  logic [31:0] hi, lo;
  logic        busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   busy_n = 0;
  int   done_n = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .issue(issue), .Mul(Mul), .Div(Div),
    .Unsigned(Unsigned), .MTHI(MTHI), .MTLO(MTLO), .op_a(op_a), .op_b(op_b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic mul, input logic uns,
                                        input logic [31:0] a, input logic [31:0] b);
    if (mul) begin
      if (uns) return {32'b0, a} * {32'b0, b};
      return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (uns) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  always @(negedge clk) begin
    if (busy) busy_n++;
    if (done) begin
      done_n++;
      chk("busy_with_done", {63'b0, busy}, 64'd0);
      chk("sb_nonempty", {63'b0, sbq.size() != 0}, 64'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e.hi});
        chk("lo", {32'b0, lo}, {32'b0, e.lo});
      end
    end
  end

  // mid: 0 none, 1 MTLO during busy, 2 second issue during busy, 3 reset at cycle 10
  task automatic run_op(input logic mul, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, input int mid,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int b0;
    int d0;
    @(negedge clk);
    Mul = mul; Div = ~mul; Unsigned = uns; op_a = a; op_b = b; issue = 1'b1;
    b0 = busy_n;
    d0 = done_n;
    if (mid != 3) sbq.push_back('{ehi, elo});
    @(posedge clk); #1;
    issue = 1'b0; Mul = 1'b0; Div = 1'b0; op_a = '0; op_b = '0;
    cyc = 0;
    while (!done && cyc < 100 && !(mid == 3 && cyc == 10)) begin
      if (mid == 1 && cyc == 5) begin MTLO = 1'b1; op_a = 32'hDEAD; end
      if (mid == 2 && cyc == 5) begin issue = 1'b1; Mul = 1'b1; Unsigned = 1'b1; op_a = 9; op_b = 9; end
      @(posedge clk); #1;
      MTLO = 1'b0; issue = 1'b0; Mul = 1'b0; op_a = '0; op_b = '0;
      cyc++;
    end
    if (mid == 3) begin
      reset = 1'b1;
      #1;
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      #1 reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", done_n - d0, 64'd0);
      chk("abort_idle", {63'b0, busy}, 64'd0);
    end else begin
      chk("latency", cyc, 64'd33);
      chk("busy_cycles", busy_n - b0, 64'd33);
      @(posedge clk); #1;
      chk("done_pulses", done_n - d0, 64'd1);
      if (mid == 2) begin
        repeat (40) @(posedge clk);
        #1;
        chk("single_done", done_n - d0, 64'd1);
        chk("idle_after", {63'b0, busy}, 64'd0);
      end
    end
  endtask

  initial begin
    logic [63:0] m;
    logic        rm, ru;
    logic [31:0] ra, rb;
    reset = 1'b1; issue = 1'b0; Mul = 1'b0; Div = 1'b0; Unsigned = 1'b0;
    MTHI = 1'b0; MTLO = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk("init_hi", {32'b0, hi}, 64'd0);
    chk("init_lo", {32'b0, lo}, 64'd0);
    chk("init_busy", {63'b0, busy}, 64'd0);
    chk("init_done", {63'b0, done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001);
    run_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd5,        0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h00000000);
    run_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(1'b0, 1'b1, 32'd7,        32'd0,        0, 32'h00000007, 32'hFFFFFFFF);
    run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h80000000);

    @(negedge clk);
    MTHI = 1'b1; op_a = 32'h1234;
    @(posedge clk); #1;
    MTHI = 1'b0; op_a = '0;
    chk("mthi_hi", {32'b0, hi}, 64'h1234);
    chk("mthi_no_done", {63'b0, done}, 64'd0);
    run_op(1'b1, 1'b1, 32'd2, 32'd3, 1, 32'd0, 32'd6);

    run_op(1'b0, 1'b1, 32'd100, 32'd7, 3, 32'd0, 32'd0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, 32'd2, 32'd14);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 2, 32'd2, 32'd14);

    for (int i = 0; i < 8; i++) begin
      rm = 1'(i % 2);
      ru = 1'((i / 2) % 2);
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i == 6) ? 32'($urandom_range(1, 20)) : $urandom);
      m = model(rm, ru, ra, rb);
      run_op(rm, ru, ra, rb, 0, m[63:32], m[31:0]);
    end

    chk("sb_drained", sbq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide responder that executes the Mul/Div/Unsigned requests raised by the control decoder.
- Owns the architectural HI/LO registers and services MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises busy so the datapath stalls MFHI/MFLO and any further issue until the result lands.
- Sits beside the ALU in the harvard datapath, fed by rs/rt register-file read data.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue  in  1  qualifies Mul/Div for one cycle (decoder output gated by execute state).
- Mul  in  1  multiply request from control.
- Div  in  1  divide request from control.
- Unsigned  in  1  1 = unsigned operation, 0 = signed.
- MTHI  in  1  write op_a to HI.
- MTLO  in  1  write op_a to LO.
- op_a  in  WIDTH  rs value: multiplicand or dividend.
- op_b  in  WIDTH  rt value: multiplier or divisor.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO take a new mul/div result.

Behaviour:
- Reset:
  - Asynchronous, active-high; clk and reset are the only clock and reset.
  - Sets hi=0, lo=0, busy=0, done=0, state=IDLE and clears the iteration counter.
  - Reset mid-operation aborts the operation; no partial result is ever written.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - issue&&Mul → MUL. Mul has priority if Mul and Div are both high.
  - issue&&Div → DIV.
  - On entry, capture |op_a| and |op_b|; for unsigned ops the raw values are used.
  - Record the sign for the quotient/product (a_sign XOR b_sign) and for the remainder (a_sign). Both are zero when Unsigned=1.
  - Load counter=WIDTH.
- MUL: shift-add, one bit per cycle, 2*WIDTH accumulator. counter decrements; after the WIDTH-th iteration → FIX.
- DIV:
  - Restoring division, one quotient bit per cycle; remainder is WIDTH+1 bits wide internally. After WIDTH iterations → FIX.
  - Divisor zero: takes the same path and latency; the result is forced to hi=op_a as captured (raw) and lo={WIDTH{1}}.
- FIX:
  - Apply two's-complement negation per the recorded signs.
  - Write hi/lo. For MUL, hi = upper half and lo = lower half. For DIV, lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - Assert done for this cycle, then → IDLE.
- Latency:
  - Issue is sampled at edge 0; hi/lo update and done rises at edge WIDTH+1.
  - busy is high from edge 0 until edge WIDTH+1, i.e. WIDTH+1 cycles; busy and done are never high together.
- Overflow: signed -2^(W-1) / -1 gives lo=0x80000000, hi=0; no trap.
- Ignored inputs:
  - issue while busy is ignored; the datapath must stall.
  - MTHI/MTLO while busy is ignored.
- MTHI/MTLO:
  - In IDLE, MTHI writes op_a to hi and MTLO writes op_a to lo on the next edge; both may be high together.
  - If issue&&(Mul||Div) is also high, the issue wins and MT* is dropped.
  - MT* writes do not assert done.
- hi/lo hold their values at all other times.

Decomposition:
- Package mips_muldiv_pkg: state enum (IDLE, MUL, DIV, FIX), the WIDTH default, the divide-by-zero LO constant.
- One natural sub-module, muldiv_sign_fix: combinational magnitude and conditional-negate helper, used on operand capture and in FIX.

Test Plan:
- MULTU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → at edge 33: hi=0xFFFFFFFE, lo=0x00000001, done pulses once; busy high for exactly 33 cycles.
- MULT op_a=-3 (0xFFFFFFFD), op_b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV op_a=-7, op_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op_a=7, op_b=0 → hi=7, lo=0xFFFFFFFF at the same latency. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- MTHI op_a=0x1234 while idle → hi=0x1234 next edge, done stays 0. Then issue MULTU 2×3, and MTLO 0xDEAD during busy → MTLO is ignored; lo=6, hi=0 at done.
- Issue DIVU 100/7 and assert reset at cycle 10 → hi=lo=0 and busy=0 immediately (asynchronous). A fresh DIVU 100/7 then yields lo=14, hi=2.
- Second issue while busy (MULTU 9×9 mid DIVU 100/7) → ignored; result lo=14, hi=2; only one done pulse.
